chunked_serial_adder: RTL and testbench

Multi-cycle, parametrised ripple adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, using a single CHUNK-bit ripple chain of full-adder cells with the carry registered between cycles. It sits next to the combinational full-adder cells as the area-saving arithmetic unit for wide operands. It has a start/busy/done handshake, an optional subtract mode, and carry-out and signed-overflow flags.

---
 rtl/chunked_serial_adder.sv | 146 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle chunked ripple adder/subtractor
// Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, carry registered between cycles.
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;
    logic [CHUNK-1:0] psum [NCHUNK];

    logic [CHUNK-1:0] a_parts [NCHUNK];
    logic [CHUNK-1:0] b_parts [NCHUNK];
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic [CHUNK:0]   carry_chain;
    logic [WIDTH-1:0] psum_full;

    // The final chunk is taken straight from the adder so the result publishes on the last RUN edge.
    for (genvar j = 0; j < NCHUNK; j++) begin : g_parts
        assign a_parts[j] = a_reg[j*CHUNK +: CHUNK];
        assign b_parts[j] = b_reg[j*CHUNK +: CHUNK];
        if (j == NCHUNK - 1) begin : g_top
            assign psum_full[j*CHUNK +: CHUNK] = chunk_sum;
        end else begin : g_low
            assign psum_full[j*CHUNK +: CHUNK] = psum[j];
        end
    end

    assign a_chunk        = a_parts[cnt];
    assign b_chunk        = b_parts[cnt];
    assign carry_chain[0] = carry_reg;
    assign last           = (cnt == LAST_CHUNK);

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign chunk_sum[i]     = a_chunk[i] ^ b_chunk[i] ^ carry_chain[i];
        assign carry_chain[i+1] = (a_chunk[i] & b_chunk[i]) |
                                  (carry_chain[i] & (a_chunk[i] ^ b_chunk[i]));
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            for (int j = 0; j < NCHUNK; j++) begin
                psum[j] <= '0;
            end
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept) begin
                a_reg     <= a;
                b_reg     <= sub ? ~b : b;
                carry_reg <= sub ? 1'b1 : carry_in;
                cnt       <= '0;
                for (int j = 0; j < NCHUNK; j++) begin
                    psum[j] <= '0;
                end
            end else if (state == RUN) begin
                psum[cnt] <= chunk_sum;
                carry_reg <= carry_chain[CHUNK];
                cnt       <= last ? '0 : cnt + CNT_W'(1);
                if (last) begin
                    sum       <= psum_full;
                    carry_out <= carry_chain[CHUNK];
                    overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - self-checking bench for chunked_serial_adder
// Five instances (W=8 with CHUNK 1/2/4/8, W=4 with CHUNK 1) each checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int finished = 0;

    function automatic void chk(input int blk, input string nm,
                                input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL g%0d %s: got 0x%0h, expected 0x%0h", blk, nm, act, exp);
        end
    endfunction

    for (genvar gi = 0; gi < 5; gi++) begin : g
        localparam int W = (gi == 4) ? 4 : 8;
        localparam int C = (gi == 4) ? 1 : (1 << gi);
        localparam int N = W / C;

        logic         rst_n;
        logic         start;
        logic         sub;
        logic         cin;
        logic         busy;
        logic         done;
        logic         cout;
        logic         ovf;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;

        chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .a         (a),
            .b         (b),
            .carry_in  (cin),
            .sub       (sub),
            .busy      (busy),
            .done      (done),
            .sum       (sum),
            .carry_out (cout),
            .overflow  (ovf)
        );

        // Plain integer arithmetic: unsigned result/carry and true signed range for overflow.
        function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s,
                                       output logic [W-1:0] r, output logic co,
                                       output logic ov);
            longint ux, uy, sx, sy, t, st, full, half;
            full = longint'(1) << W;
            half = full / 2;
            ux   = longint'(x);
            uy   = longint'(y);
            sx   = (ux >= half) ? ux - full : ux;
            sy   = (uy >= half) ? uy - full : uy;
            if (s) begin
                t  = ux - uy;
                co = (t >= 0);
                st = sx - sy;
            end else begin
                t  = ux + uy + longint'(ci);
                co = (t >= full);
                st = sx + sy + longint'(ci);
            end
            r  = W'(t);
            ov = (st < -half) || (st >= half);
        endfunction

        int           m_left = 0;
        bit           m_done = 1'b0;
        bit           armed  = 1'b0;
        logic [W-1:0] e_sum  = '0;
        logic [W-1:0] p_sum  = '0;
        logic         e_c = 1'b0, e_o = 1'b0, p_c = 1'b0, p_o = 1'b0;

        always @(posedge clk) begin
            if (!rst_n) begin
                m_left = 0;
                m_done = 1'b0;
                e_sum  = '0;
                e_c    = 1'b0;
                e_o    = 1'b0;
                armed  = 1'b1;
            end else if (armed) begin
                m_done = 1'b0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        e_sum  = p_sum;
                        e_c    = p_c;
                        e_o    = p_o;
                    end
                end else if (start) begin
                    ref_op(a, b, cin, sub, p_sum, p_c, p_o);
                    m_left = N;
                end
            end
            #2;
            if (armed) begin
                chk(gi, "busy",      64'(busy), 64'(m_left > 0));
                chk(gi, "done",      64'(done), 64'(m_done));
                chk(gi, "sum",       64'(sum),  64'(e_sum));
                chk(gi, "carry_out", 64'(cout), 64'(e_c));
                chk(gi, "overflow",  64'(ovf),  64'(e_o));
            end
        end

        task automatic do_reset();
            rst_n = 1'b0;
            start = 1'b0;
            a     = '0;
            b     = '0;
            cin   = 1'b0;
            sub   = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        endtask

        // Called on a negedge; returns on the negedge where done is seen.
        task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic tc, input logic ts);
            int lat;
            a     = ta;
            b     = tb_v;
            cin   = tc;
            sub   = ts;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat   = 0;
            while (!done && lat <= N + 4) begin
                @(negedge clk);
                lat++;
            end
            chk(gi, "latency", 64'(lat), 64'(N));
        endtask

        task automatic random_ops(input int n);
            int gap;
            for (int k = 0; k < n; k++) begin
                issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                a   = W'($urandom);
                b   = W'($urandom);
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
            end
        endtask

        if (gi == 1) begin : g_directed
            initial begin
                int busy_cnt;
                int guard;
                int done_cnt;
                do_reset();
                issue(8'hFF, 8'h01, 1'b0, 1'b0);
                chk(gi, "ff+01 sum", 64'(sum), 64'h00);
                chk(gi, "ff+01 cout", 64'(cout), 64'h1);
                chk(gi, "ff+01 ovf", 64'(ovf), 64'h0);
                issue(8'h7F, 8'h01, 1'b0, 1'b0);
                chk(gi, "7f+01 sum", 64'(sum), 64'h80);
                chk(gi, "7f+01 cout", 64'(cout), 64'h0);
                chk(gi, "7f+01 ovf", 64'(ovf), 64'h1);
                issue(8'h10, 8'h20, 1'b1, 1'b0);
                chk(gi, "10+20+1 sum", 64'(sum), 64'h31);
                issue(8'h05, 8'h07, 1'b1, 1'b1);
                chk(gi, "05-07 sum", 64'(sum), 64'hFE);
                chk(gi, "05-07 cout", 64'(cout), 64'h0);
                chk(gi, "05-07 ovf", 64'(ovf), 64'h0);
                issue(8'h80, 8'h01, 1'b0, 1'b1);
                chk(gi, "80-01 sum", 64'(sum), 64'h7F);
                chk(gi, "80-01 cout", 64'(cout), 64'h1);
                chk(gi, "80-01 ovf", 64'(ovf), 64'h1);

                // start held and operands scrambled while busy
                a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
                @(negedge clk);
                busy_cnt = 0;
                guard    = 0;
                while (!done && guard < 20) begin
                    if (busy) busy_cnt++;
                    chk(gi, "held sum", 64'(sum), 64'h7F);
                    start = 1'b1;
                    a     = W'($urandom);
                    b     = W'($urandom);
                    cin   = 1'($urandom);
                    sub   = 1'($urandom);
                    @(negedge clk);
                    guard++;
                end
                start = 1'b0;
                chk(gi, "busy cycles", 64'(busy_cnt), 64'(N));
                chk(gi, "33+44 sum", 64'(sum), 64'h77);
                chk(gi, "33+44 cout", 64'(cout), 64'h0);

                // reset lands on the edge that would process chunk 2
                @(negedge clk);
                a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk(gi, "rst busy", 64'(busy), 64'h0);
                chk(gi, "rst done", 64'(done), 64'h0);
                chk(gi, "rst sum", 64'(sum), 64'h0);
                chk(gi, "rst cout", 64'(cout), 64'h0);
                chk(gi, "rst ovf", 64'(ovf), 64'h0);
                done_cnt = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                chk(gi, "no done after reset", 64'(done_cnt), 64'h0);
                issue(8'h01, 8'h02, 1'b0, 1'b0);
                chk(gi, "post-reset sum", 64'(sum), 64'h03);

                random_ops(100);
                finished++;
            end
        end else if (gi == 4) begin : g_exhaustive
            initial begin
                time t_prev;
                bit  first;
                do_reset();
                first  = 1'b1;
                t_prev = 0;
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        for (int c = 0; c < 2; c++) begin
                            for (int s = 0; s < 2; s++) begin
                                issue(W'(x), W'(y), 1'(c), 1'(s));
                                if (!first) begin
                                    chk(gi, "throughput", 64'($time - t_prev), 64'((N + 1) * 10));
                                end
                                t_prev = $time;
                                first  = 1'b0;
                            end
                        end
                    end
                end
                start = 1'b0;
                finished++;
            end
        end else begin : g_random
            initial begin
                do_reset();
                random_ops(150);
                finished++;
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (finished < 5 && cyc < 40000) begin
            @(posedge clk);
            cyc++;
        end
        if (finished < 5) begin
            n_checks++;
            n_fail++;
            $display("FAIL run timeout: %0d blocks finished, expected 5", finished);
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
